// File: rtl/data_mem_unit.sv
// Data-side memory for the 16-bit CPU: services DA/DD/RW loads and stores on negedge CK,
// with preload, debug read, store counter and sticky DONE/ERR/COLL status flags.
module data_mem_unit #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 128,
  parameter int               AW        = 7,
  parameter logic [15:0]      HALT_ADDR = 16'h0,
  parameter logic [WIDTH-1:0] HALT_VAL  = 16'h4
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [15:0]      DA,
  inout  wire  [WIDTH-1:0] DD,
  input  logic             RW,
  input  logic             PL_WE,
  input  logic [AW-1:0]    PL_ADDR,
  input  logic [WIDTH-1:0] PL_DATA,
  input  logic [AW-1:0]    DBG_ADDR,
  output logic [WIDTH-1:0] DBG_DATA,
  output logic             DONE,
  output logic             ERR,
  output logic             COLL,
  output logic [15:0]      WCNT
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] rd_q, rd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             coll_q, coll_d;
  logic [15:0]      wcnt_q, wcnt_d;

  logic             in_range;
  logic             cpu_wr;
  logic             cpu_commit;
  logic [AW-1:0]    cpu_idx;

  // Full 16-bit compare so upper address bits can never alias into the array.
  assign in_range   = (DA < DEPTH_W);
  assign cpu_idx    = DA[AW-1:0];
  assign cpu_wr     = ~RW;
  assign cpu_commit = cpu_wr & in_range & ~PL_WE;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_d   = rd_q;
    done_d = done_q;
    err_d  = err_q;
    coll_d = coll_q;
    wcnt_d = wcnt_q;
    if (RW) begin
      rd_d = in_range ? mem_q[cpu_idx] : '0;
    end
    if (!in_range) begin
      err_d = 1'b1;
    end
    if (PL_WE && cpu_wr) begin
      coll_d = 1'b1;
    end
    if (cpu_commit) begin
      wcnt_d = wcnt_q + 16'd1;
      if (DA == HALT_ADDR && DD == HALT_VAL) begin
        done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(negedge CK or negedge RST) begin
    if (!RST) begin
      rd_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      coll_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      rd_q   <= rd_d;
      done_q <= done_d;
      err_q  <= err_d;
      coll_q <= coll_d;
      wcnt_q <= wcnt_d;
    end
  end

  // NOTE: the array has no reset; contents survive RST, and preload stays live during reset.
  always_ff @(negedge CK) begin
    if (PL_WE) begin
      mem_q[PL_ADDR] <= PL_DATA;
    end else if (RST && cpu_commit) begin
      mem_q[cpu_idx] <= DD;
    end
  end

  assign DD       = RW ? rd_q : {WIDTH{1'bz}};
  assign DBG_DATA = mem_q[DBG_ADDR];
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign COLL     = coll_q;
  assign WCNT     = wcnt_q;

endmodule
